// File: rtl/ifm_pingpong_buf.sv
// Ping-pong input feature-map tile buffer: two banks are filled word by word
// and presented whole. Partial tiles are zero-padded on the read side.

module ifm_pp_word #(
  parameter int WORD_W = 64,
  parameter int CNT_W  = 4,
  parameter int IDX    = 0
) (
  input  logic              valid,
  input  logic [CNT_W-1:0]  cnt,
  input  logic [WORD_W-1:0] word,
  output logic [WORD_W-1:0] padded
);
  // Words beyond the tile's stored count read as zero, so stale bank data never leaks.
  assign padded = (valid && (CNT_W'(IDX) < cnt)) ? word : '0;
endmodule

module ifm_pingpong_buf #(
  parameter int DATA_W = 16,
  parameter int LANES  = 4,
  parameter int DEPTH  = 11
) (
  input  logic                          clk,
  input  logic                          rst_na,
  input  logic [LANES*DATA_W-1:0]       in_data,
  input  logic                          in_valid,
  input  logic                          in_last,
  output logic                          in_ready,
  input  logic                          flush,
  input  logic                          hs_signal,
  output logic                          data_valid,
  output logic [LANES*DATA_W*DEPTH-1:0] data_out,
  output logic [1:0]                    fill_level
);
  localparam int WORD_W = LANES * DATA_W;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int WC_W   = $clog2(DEPTH);

  logic [WORD_W-1:0]       mem [2][DEPTH];
  logic [1:0]              full, full_nxt;
  logic [1:0][CNT_W-1:0]   cnt;
  logic [WC_W-1:0]         wcnt;
  logic                    wr_bank, rd_bank;
  logic                    accept, close, retire;

  assign in_ready   = !full[wr_bank] && !flush;
  assign accept     = in_valid && in_ready;
  assign close      = accept && ((wcnt == WC_W'(DEPTH - 1)) || in_last);
  assign retire     = hs_signal && full[rd_bank] && !flush;
  assign data_valid = full[rd_bank];
  assign fill_level = 2'(full[0]) + 2'(full[1]);

  // Closing and retiring always target different banks (accept needs !full).
  always_comb begin
    full_nxt = full;
    if (close)  full_nxt[wr_bank] = 1'b1;
    if (retire) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_na) begin
    if (!rst_na) begin
      full    <= '0;
      cnt     <= '0;
      wcnt    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else if (flush) begin
      full    <= '0;
      cnt     <= '0;
      wcnt    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      full <= full_nxt;
      if (close) begin
        cnt[wr_bank] <= CNT_W'(wcnt) + CNT_W'(1);
        wcnt         <= '0;
        wr_bank      <= ~wr_bank;
      end else if (accept) begin
        wcnt <= wcnt + WC_W'(1);
      end
      if (retire) rd_bank <= ~rd_bank;
    end
  end

  // Storage is not reset; the read path masks it until a tile is closed.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_bank][wcnt] <= in_data;
  end

  for (genvar w = 0; w < DEPTH; w++) begin : g_word
    ifm_pp_word #(.WORD_W(WORD_W), .CNT_W(CNT_W), .IDX(w)) u_word (
      .valid  (data_valid),
      .cnt    (cnt[rd_bank]),
      .word   (mem[rd_bank][w]),
      .padded (data_out[w*WORD_W +: WORD_W])
    );
  end
endmodule

// File: doc/ifm_pingpong_buf.md
IFM_PINGPONG_BUF -- requirements
Module: ifm_pingpong_buf

Interface
REQ-001 Parameter DATA_W, default 16: width of one feature-map element in bits.
REQ-002 Parameter LANES, default 4: elements (channels) per input word.
REQ-003 Parameter DEPTH, default 11: input words per tile; DEPTH >= 2.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_na  in  1  reset, asynchronous and active-low.
REQ-006 in_data  in  LANES*DATA_W  input word; lane l occupies bits [l*DATA_W +: DATA_W].
REQ-007 in_valid  in  1  in_data is valid this cycle.
REQ-008 in_last  in  1  qualified by in_valid; marks the final word of a partial tile.
REQ-009 in_ready  out  1  buffer can accept a word this cycle.
REQ-010 flush  in  1  synchronous clear of all tiles and pointers.
REQ-011 hs_signal  in  1  consumer acknowledge; retires the presented tile.
REQ-012 data_valid  out  1  a complete tile is presented on data_out.
REQ-013 data_out  out  LANES*DATA_W*DEPTH  whole tile, presented in parallel.
REQ-014 fill_level  out  2  number of full banks (0..2).

Function
REQ-015 The block SHALL hold two banks (0, 1); each bank SHALL store DEPTH words, a full flag and a word count of clog2(DEPTH+1) bits.
REQ-016 The block SHALL keep a write-bank pointer wr_bank, a word counter wcnt (0..DEPTH-1) and a read-bank pointer rd_bank.
REQ-017 in_ready SHALL equal !full[wr_bank] && !flush, as a combinational output.
REQ-018 Accept = in_valid && in_ready; on accept the block SHALL store in_data at bank[wr_bank] word wcnt.
REQ-019 An accept with wcnt==DEPTH-1 or in_last=1 SHALL close the tile: full[wr_bank]<=1, count[wr_bank]<=wcnt+1, wcnt<=0, wr_bank toggles.
REQ-020 Any other accept SHALL increment wcnt only.
REQ-021 The block SHALL ignore in_last when in_valid=0 or in_ready=0.
REQ-022 data_valid SHALL equal full[rd_bank].
REQ-023 When data_valid=1, element (word w, lane l) SHALL appear at data_out bits [(w*LANES+l)*DATA_W +: DATA_W], giving word-major, lane-minor interleaving.
REQ-024 Words with index >= count[rd_bank] SHALL read as zero (zero padding for partial tiles).
REQ-025 data_out SHALL be all zeros when data_valid=0.
REQ-026 data_out SHALL remain stable while data_valid=1 and hs_signal=0.
REQ-027 hs_signal with data_valid=1 SHALL clear full[rd_bank] and toggle rd_bank on the same edge.
REQ-028 hs_signal with data_valid=0 SHALL have no effect.
REQ-029 Latency: a closing accept at edge N SHALL give data_valid=1 after edge N if that bank is rd_bank, otherwise after the edge that retires the other bank.
REQ-030 Simultaneous closing accept and hs_signal on different banks SHALL both take effect; fill_level is unchanged.
REQ-031 A closing accept and hs_signal on the same bank cannot coincide, because accept requires !full; no arbitration is required.
REQ-032 When both banks are full, in_ready=0; the input SHALL stall without data loss until hs_signal.
REQ-033 Throughput: with hs_signal held high, the block SHALL sustain one accepted word per cycle indefinitely.
REQ-034 flush=1 SHALL clear both full flags, wcnt, wr_bank and rd_bank on the next edge and SHALL discard any partial tile.
REQ-035 flush SHALL take priority over simultaneous accept or hs_signal.
REQ-036 fill_level SHALL equal full[0] + full[1].

Reset
REQ-037 rst_na=0 SHALL immediately clear full[1:0], counts, wcnt, wr_bank and rd_bank, independent of clk.
REQ-038 During and after reset, outputs SHALL be: data_valid=0, data_out=0, fill_level=0, in_ready=1 (unless flush=1).
REQ-039 Bank data storage need not be reset; zero output is guaranteed by REQ-025.
REQ-040 Reset asserted mid-tile SHALL discard the partial tile; the first accept after release SHALL land at bank 0 word 0.

Verification
REQ-041 Full tile: 11 words with lane l of word w = 16'h(w<<4 | l) -> data_valid=1 after the 11th accept edge; data_out bits [(w*4+l)*16 +: 16] = 16'h(w<<4 | l).
REQ-042 Back-pressure: 22 words with hs_signal=0 -> fill_level=2 and in_ready=0; the 23rd word stalls; hs_signal -> bank 1 presented and in_ready=1 next cycle.
REQ-043 Partial tile: 5 words, in_last on the 5th -> data_valid=1; words 5..10 read as zero; the next tile starts in bank 1 at word 0.
REQ-044 Streaming: continuous in_valid=1, hs_signal=1 for 110 words -> in_ready never 0; 10 tiles are presented in order.
REQ-045 Flush at wcnt=6 with bank 0 full -> next cycle fill_level=0, data_valid=0, data_out=0; the next accept lands at bank 0 word 0.
REQ-046 Reset pulsed mid-tile asynchronously (between edges) -> outputs take reset values before the next edge; a subsequent full tile matches REQ-041.
